// File: rtl/acc_alu_pkg.sv
// Shared encodings for the sequenced accumulator ALU: opcodes, FSM states and
// operand-B source selects.
package acc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MUL     = 4'd2,
    OP_DIV     = 4'd3,
    OP_AND     = 4'd4,
    OP_OR      = 4'd5,
    OP_XOR     = 4'd6,
    OP_NOT     = 4'd7,
    OP_NAND    = 4'd8,
    OP_NOR     = 4'd9,
    OP_XNOR    = 4'd10,
    OP_SHL     = 4'd11,
    OP_SHR     = 4'd12,
    OP_NOP     = 4'd13,
    OP_CLEAR   = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_ERROR = 2'b10
  } state_e;

  localparam logic [1:0] BSEL_ZERO = 2'b00;
  localparam logic [1:0] BSEL_B    = 2'b01;
  localparam logic [1:0] BSEL_ACC  = 2'b10;
  localparam logic [1:0] BSEL_HOLD = 2'b11;

endpackage

// File: rtl/acc_alu_div.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles after
// start. done is high during the last iteration with quotient already final.
module acc_alu_div
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_nxt, quo_nxt;
  logic [WIDTH:0]   shifted, diff;
  logic [CW-1:0]    cnt_q;

  // A borrow out of the trial subtract means the shifted remainder is restored.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done     = (cnt_q == CW'(1));
  assign quotient = quo_nxt;

endmodule

// File: rtl/acc_alu_seq.sv
// Handshaked accumulator ALU with a multi-cycle divider and READY/BUSY/ERROR FSM.
// Define ACC_ALU_SAT_EN to make sub underflow saturate to zero instead of erroring.
module acc_alu_seq
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic               a_sel,
  input  logic [1:0]         b_sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               out_valid,
  output logic               busy,
  output logic               error,
  output logic [1:0]         state
);
  localparam int ACC_W = 2*WIDTH;
  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(ACC_W);

  state_e           st_q, st_nxt;
  op_e              opc;
  logic [WIDTH-1:0] a_q, b_q, eff_a, eff_b, quotient;
  logic [ACC_W-1:0] xa, xb, alu_res, res;
  logic             accept, upd, pulse, div_start, div_done;

  assign opc      = op_e'(op);
  assign in_ready = (st_q != ST_BUSY);
  assign accept   = in_valid & in_ready;
  assign busy     = (st_q == ST_BUSY);
  assign error    = (st_q == ST_ERROR);
  assign state    = st_q;

  assign eff_a = a_sel ? a : a_q;
  always_comb begin
    case (b_sel)
      BSEL_ZERO: eff_b = '0;
      BSEL_B:    eff_b = b;
      BSEL_ACC:  eff_b = acc[WIDTH-1:0];
      default:   eff_b = b_q;
    endcase
  end

  assign xa = {{WIDTH{1'b0}}, eff_a};
  assign xb = {{WIDTH{1'b0}}, eff_b};

  always_comb begin
    alu_res = acc;
    case (opc)
      OP_ADD:  alu_res = xa + xb;
      OP_SUB:  alu_res = {{WIDTH{1'b0}}, eff_a - eff_b};
      OP_MUL:  alu_res = xa * xb;
      OP_AND:  alu_res = {{WIDTH{1'b0}}, eff_a & eff_b};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, eff_a | eff_b};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, eff_a ^ eff_b};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~eff_b};
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(eff_a & eff_b)};
      OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(eff_a | eff_b)};
      OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(eff_a ^ eff_b)};
      OP_SHL:  alu_res = (eff_a >= SH_LIM) ? '0 : xb << eff_a[SHW-1:0];
      OP_SHR:  alu_res = (eff_a >= SH_LIM) ? '0 : xb >> eff_a[SHW-1:0];
      default: alu_res = acc;
    endcase
  end

  always_comb begin
    st_nxt    = st_q;
    res       = alu_res;
    upd       = 1'b0;
    pulse     = 1'b0;
    div_start = 1'b0;
    case (st_q)
      ST_READY: begin
        if (accept) begin
          case (opc)
            OP_DIV: begin
              if (eff_b == '0) st_nxt = ST_ERROR;
              else begin
                st_nxt    = ST_BUSY;
                div_start = 1'b1;
              end
            end
            OP_SUB: begin
              if (eff_b > eff_a) begin
`ifdef ACC_ALU_SAT_EN
                res   = '0;
                upd   = 1'b1;
                pulse = 1'b1;
`else
                st_nxt = ST_ERROR;
`endif
              end else begin
                upd   = 1'b1;
                pulse = 1'b1;
              end
            end
            OP_CLEAR: begin
              res   = '0;
              upd   = 1'b1;
              pulse = 1'b1;
            end
            OP_ILLEGAL: st_nxt = ST_ERROR;
            OP_NOP:     pulse  = 1'b1;
            default: begin
              upd   = 1'b1;
              pulse = 1'b1;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          res    = {{WIDTH{1'b0}}, quotient};
          upd    = 1'b1;
          pulse  = 1'b1;
          st_nxt = ST_READY;
        end
      end
      ST_ERROR: begin
        // Everything but clear is swallowed while in error.
        if (accept && opc == OP_CLEAR) begin
          res    = '0;
          upd    = 1'b1;
          pulse  = 1'b1;
          st_nxt = ST_READY;
        end
      end
      default: st_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= ST_READY;
    else        st_q <= st_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pulse;
      if (upd) acc <= res;
      if (accept) begin
        a_q <= eff_a;
        b_q <= eff_b;
      end
    end
  end

  acc_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (eff_a),
    .divisor  (eff_b),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq: arithmetic reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_acc_alu_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, a_sel;
  logic [3:0]  op;
  logic [1:0]  b_sel;
  logic [15:0] a, b;
  logic [31:0] acc;
  logic        out_valid, busy, error;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  acc_alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a_sel(a_sel), .b_sel(b_sel), .a(a), .b(b), .acc(acc),
    .out_valid(out_valid), .busy(busy), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0 ready, 1 dividing, 2 error.
  logic [31:0] m_acc = '0, m_q = '0;
  logic [15:0] m_aq = '0, m_bq = '0;
  int          m_mode = 0, m_cnt = 0;
  logic        m_ov = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    logic [15:0] ea, eb;
    logic [31:0] xa, xb;
    if (!reset) begin
      m_acc = '0; m_aq = '0; m_bq = '0; m_mode = 0; m_cnt = 0; m_ov = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (m_mode == 1) begin
        m_cnt--;
        if (m_cnt == 0) begin m_acc = m_q; m_mode = 0; m_ov = 1'b1; end
      end else if (in_valid) begin
        ea = a_sel ? a : m_aq;
        case (b_sel)
          2'd0: eb = '0;
          2'd1: eb = b;
          2'd2: eb = m_acc[15:0];
          default: eb = m_bq;
        endcase
        m_aq = ea; m_bq = eb;
        xa = {16'b0, ea}; xb = {16'b0, eb};
        if (op == 4'd14) begin
          m_acc = '0; m_mode = 0; m_ov = 1'b1;
        end else if (m_mode == 0) begin
          case (op)
            4'd0:  begin m_acc = xa + xb; m_ov = 1'b1; end
            4'd1: begin
              if (eb > ea) begin
`ifdef ACC_ALU_SAT_EN
                m_acc = '0; m_ov = 1'b1;
`else
                m_mode = 2;
`endif
              end else begin m_acc = xa - xb; m_ov = 1'b1; end
            end
            4'd2:  begin m_acc = xa * xb; m_ov = 1'b1; end
            4'd3: begin
              if (eb == 0) m_mode = 2;
              else begin m_q = xa / xb; m_cnt = 16; m_mode = 1; end
            end
            4'd4:  begin m_acc = xa & xb; m_ov = 1'b1; end
            4'd5:  begin m_acc = xa | xb; m_ov = 1'b1; end
            4'd6:  begin m_acc = xa ^ xb; m_ov = 1'b1; end
            4'd7:  begin m_acc = {16'b0, ~eb}; m_ov = 1'b1; end
            4'd8:  begin m_acc = {16'b0, ~(ea & eb)}; m_ov = 1'b1; end
            4'd9:  begin m_acc = {16'b0, ~(ea | eb)}; m_ov = 1'b1; end
            4'd10: begin m_acc = {16'b0, ~(ea ^ eb)}; m_ov = 1'b1; end
            4'd11: begin m_acc = (ea >= 32) ? 32'd0 : xb << ea; m_ov = 1'b1; end
            4'd12: begin m_acc = (ea >= 32) ? 32'd0 : xb >> ea; m_ov = 1'b1; end
            4'd13: m_ov = 1'b1;
            default: m_mode = 2;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("cmp_acc", acc, m_acc);
      chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      chk("cmp_busy", {31'b0, busy}, {31'b0, (m_mode == 1)});
      chk("cmp_error", {31'b0, error}, {31'b0, (m_mode == 2)});
      chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, (m_mode != 1)});
      chk("cmp_state", {30'b0, state}, 32'(m_mode));
    end
  end

  task automatic issue(input logic [3:0] o, input logic as, input logic [1:0] bs,
                       input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    op = o; a_sel = as; b_sel = bs; a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp_cycles);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp_cycles);
  endtask

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; op = '0; a_sel = 1'b0; b_sel = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_state", {30'b0, state}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_flags", {29'b0, out_valid, busy, error}, 0);

    issue(4'd0, 1, 2'b01, 16'd5, 16'd6);
    chk("add_5_6", acc, 32'd11);
    chk("add_5_6_ov", {31'b0, out_valid}, 1);
    issue(4'd0, 1, 2'b10, 16'd42, 16'd0);
    chk("add_acc", acc, 32'd53);

    issue(4'd1, 1, 2'b10, 16'd12, 16'd0);
`ifdef ACC_ALU_SAT_EN
    chk("sub_sat_acc", acc, 32'd0);
    chk("sub_sat_ov", {31'b0, out_valid}, 1);
`else
    chk("sub_uf_state", {30'b0, state}, 32'd2);
    chk("sub_uf_acc", acc, 32'd53);
    chk("sub_uf_ov", {31'b0, out_valid}, 0);
    issue(4'd0, 1, 2'b01, 16'd1, 16'd1);
    chk("err_ignore_acc", acc, 32'd53);
    chk("err_ignore_ov", {31'b0, out_valid}, 0);
`endif
    issue(4'd14, 1, 2'b00, 16'd0, 16'd0);
    chk("clear_acc", acc, 0);
    chk("clear_state", {30'b0, state}, 0);
    chk("clear_ov", {31'b0, out_valid}, 1);

    issue(4'd2, 1, 2'b01, 16'd2048, 16'd16);
    chk("mul", acc, 32'd32768);

    // Divide with in_valid held high while busy; none of it may be accepted.
    @(negedge clk);
    op = 4'd3; a_sel = 1; b_sel = 2'b01; a = 16'd2048; b = 16'd16; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 16'd1; b = 16'd1;
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk("div_in_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("div_busy_cycles", n, 16);
    chk("div_quot", acc, 32'd128);
    chk("div_ov", {31'b0, out_valid}, 1);
    @(negedge clk);
    chk("div_ov_once", {31'b0, out_valid}, 0);

    issue(4'd3, 1, 2'b00, 16'd5, 16'd0);
    chk("div0_busy", {31'b0, busy}, 0);
    chk("div0_state", {30'b0, state}, 32'd2);
    issue(4'd14, 1, 2'b00, 16'd0, 16'd0);

    issue(4'd0, 1, 2'b01, 16'd20, 16'd30);
    issue(4'd3, 1, 2'b01, 16'd100, 16'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_acc", acc, 0);
    chk("midrst_flags", {29'b0, out_valid, busy, error}, 0);
    chk("midrst_state", {30'b0, state}, 0);
    chk("midrst_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    #3 reset = 1'b1;
    issue(4'd0, 1, 2'b01, 16'd3, 16'd4);
    chk("post_rst_add", acc, 32'd7);

    issue(4'd4, 1, 2'b01, 16'h4B7A, 16'h0D6A);
    chk("and", acc, 32'h0000_096A);
    issue(4'd7, 1, 2'b10, 16'd0, 16'd0);
    chk("not_acc", acc, 32'h0000_F695);
    issue(4'd11, 1, 2'b01, 16'd6, 16'd5);
    chk("shl_6", acc, 32'd320);
    issue(4'd11, 1, 2'b01, 16'd40, 16'd5);
    chk("shl_40", acc, 32'd0);
    issue(4'd12, 1, 2'b01, 16'd5, 16'h0140);
    chk("shr_5", acc, 32'd10);
    issue(4'd11, 1, 2'b01, 16'd31, 16'd1);
    chk("shl_31", acc, 32'h8000_0000);
    issue(4'd12, 1, 2'b01, 16'd32, 16'hFFFF);
    chk("shr_32", acc, 32'd0);
    issue(4'd0, 1, 2'b01, 16'hFFFF, 16'hFFFF);
    chk("add_carry", acc, 32'h0001_FFFE);
    issue(4'd2, 1, 2'b01, 16'hFFFF, 16'hFFFF);
    chk("mul_max", acc, 32'hFFFE_0001);
    issue(4'd1, 1, 2'b01, 16'd20, 16'd7);
    chk("sub_ok", acc, 32'd13);
    issue(4'd1, 1, 2'b01, 16'd9, 16'd9);
    chk("sub_eq", acc, 32'd0);

    // Remaining ops rely on the per-cycle model comparison.
    issue(4'd5, 1, 2'b01, 16'h00F0, 16'h0F00);
    issue(4'd6, 0, 2'b11, 16'd0, 16'd0);
    issue(4'd8, 1, 2'b01, 16'hFF00, 16'h0FF0);
    issue(4'd9, 1, 2'b01, 16'h1234, 16'h4321);
    issue(4'd10, 0, 2'b10, 16'd0, 16'd0);
    issue(4'd13, 1, 2'b01, 16'd1, 16'd2);

    issue(4'd3, 1, 2'b01, 16'd1000, 16'd3);
    wait_idle("div2_cycles", 16);
    chk("div2_quot", acc, 32'd333);
    issue(4'd3, 1, 2'b01, 16'hFFFF, 16'd1);
    wait_idle("div3_cycles", 16);
    chk("div3_quot", acc, 32'h0000_FFFF);

    issue(4'd15, 1, 2'b01, 16'd1, 16'd1);
    chk("illegal_state", {30'b0, state}, 32'd2);
    chk("illegal_err", {31'b0, error}, 1);
    issue(4'd13, 1, 2'b01, 16'd1, 16'd1);
    chk("err_nop_ov", {31'b0, out_valid}, 0);
    issue(4'd14, 1, 2'b00, 16'd0, 16'd0);
    chk("final_clear_state", {30'b0, state}, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
